controle_servo_multi: RTL and testbench
=======================================

CONTROLE_SERVO_MULTI -- requirements
Module: controle_servo_multi

Interface
REQ-001 Parameter N_CANAIS, default 2: number of independent servo channels (1..8).
REQ-002 Parameter POS_W, default 3: position code width per channel.
REQ-003 Parameter PERIODO, default 1000000: PWM period in clock cycles.
REQ-004 Parameter LARGURA_MIN, default 35000: pulse width in cycles for position code 0.
REQ-005 Parameter LARGURA_MAX, default 110000: pulse width in cycles for the all-ones position code.
REQ-006 Parameter PASSO, default 2000: maximum width change per period per channel (slew limit), PASSO >= 1.
REQ-007 clock  in  1  single system clock, all logic rising-edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 habilita  in  1  1 = PWM running; 0 = outputs forced low, counter held at 0.
REQ-010 carrega  in  1  one-cycle strobe latching posicao into all channel targets.
REQ-011 posicao  in  N_CANAIS*POS_W  packed position codes, channel i at bits [i*POS_W +: POS_W].
REQ-012 controle  out  N_CANAIS  registered PWM output per channel.
REQ-013 pronto  out  1  1 when every channel's current width equals its target width.
REQ-014 db_posicao  out  N_CANAIS*POS_W  latched target codes.
REQ-015 db_reset  out  1  copy of reset.

Function
REQ-016 DELTA = (LARGURA_MAX-LARGURA_MIN)/(2^POS_W-1), integer-truncated, elaboration-time constant; target width = LARGURA_MIN + code*DELTA.
REQ-017 Shared counter 0..PERIODO-1, increments each cycle while habilita=1, wraps PERIODO-1 -> 0.
REQ-018 controle[i] registered: next value = habilita AND (counter < atual[i]); one-cycle latency from counter.
REQ-019 carrega=1 latches all targets on that edge; targets otherwise hold; carrega repeated with same codes has no effect.
REQ-020 atual[i] updates only on the cycle counter==PERIODO-1 (period boundary), never mid-period.
REQ-021 At boundary: |target-atual| <= PASSO -> atual=target; else atual moves toward target by exactly PASSO.
REQ-022 carrega coinciding with boundary: step uses the previous target; new target applies from the next boundary.
REQ-023 Target changed mid-ramp: ramp redirects at next boundary, no overshoot beyond target.
REQ-024 habilita=0: counter cleared to 0, controle low next cycle, atual frozen, carrega still latches targets.
REQ-025 pronto combinational from atual==target for all channels; may drop on the cycle after carrega.
REQ-026 Width arithmetic sized ceil(log2(PERIODO+1)) bits; no overflow with LARGURA_MAX < PERIODO.

Reset
REQ-027 reset low: counter=0, all targets=code 0, all atual=LARGURA_MIN, controle=0, db_posicao=0, pronto=1.
REQ-028 reset asserted mid-period or mid-ramp aborts immediately; ramp restarts from LARGURA_MIN after release.

Structure
REQ-029 Shared package holds DELTA computation, counter-width function and default constants (PERIODO, LARGURA_MIN/MAX, PASSO).
REQ-030 One sub-module canal_servo (target register, slew ramp, compare, output flop), instantiated N_CANAIS times; counter lives in top.

Verification (PERIODO=100, LARGURA_MIN=10, LARGURA_MAX=80, POS_W=3 -> DELTA=10, PASSO=20, N_CANAIS=2)
REQ-031 Reset release, habilita=1, no carrega -> both controle high 10 cycles/period, pronto=1.
REQ-032 carrega with ch0=7, ch1=0 -> ch0 widths 30,50,70,80 over successive periods, ch1 stays 10; pronto=1 after 4th boundary.
REQ-033 ch0 ramping at 50 toward 80, carrega ch0=2 -> next boundary width 30, then 30 holds; no value above 50 seen.
REQ-034 carrega on counter==99 cycle with ch1=1 -> that boundary width stays 10, following boundary 20.
REQ-035 habilita=0 mid-period -> controle low next cycle, counter 0, widths frozen; habilita=1 resumes from frozen widths.
REQ-036 reset pulse mid-ramp -> controle=0 immediately, widths return to 10, db_posicao=0, pronto=1.

Source files
------------

// File: rtl/controle_servo_multi_pkg.sv
// rtl/controle_servo_multi_pkg.sv - shared constants and elaboration helpers for the servo controller
package controle_servo_multi_pkg;

    localparam int PERIODO_PADRAO     = 1000000;
    localparam int LARGURA_MIN_PADRAO = 35000;
    localparam int LARGURA_MAX_PADRAO = 110000;
    localparam int PASSO_PADRAO       = 2000;

    function automatic int largura_contador(input int periodo);
        return $clog2(periodo + 1);
    endfunction

    // Width increment per code step; truncation keeps the top code at or below LARGURA_MAX.
    function automatic int calc_delta(input int lmin, input int lmax, input int pos_w);
        return (lmax - lmin) / ((1 << pos_w) - 1);
    endfunction

endpackage

// File: rtl/canal_servo.sv
// rtl/canal_servo.sv - one servo channel: target latch, slew-limited ramp, PWM compare
module canal_servo
    import controle_servo_multi_pkg::*;
#(
    parameter int POS_W       = 3,
    parameter int CNT_W       = largura_contador(PERIODO_PADRAO),
    parameter int LARGURA_MIN = LARGURA_MIN_PADRAO,
    parameter int DELTA       = calc_delta(LARGURA_MIN_PADRAO, LARGURA_MAX_PADRAO, 3),
    parameter int PASSO       = PASSO_PADRAO
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             habilita,
    input  logic             carrega,
    input  logic             fim_periodo,
    input  logic [POS_W-1:0] codigo,
    input  logic [CNT_W-1:0] contador,
    output logic             controle,
    output logic [POS_W-1:0] alvo_codigo,
    output logic             pronto
);

    localparam logic [CNT_W-1:0] PASSO_W = CNT_W'(PASSO);
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(LARGURA_MIN);
    localparam logic [CNT_W-1:0] DELTA_W = CNT_W'(DELTA);

    logic [CNT_W-1:0] alvo;
    logic [CNT_W-1:0] atual;
    logic [CNT_W-1:0] proximo;

    assign alvo   = MIN_W + CNT_W'(alvo_codigo) * DELTA_W;
    assign pronto = (atual == alvo);

    // Move by at most PASSO; land exactly on the target so a redirect never overshoots.
    always_comb begin
        proximo = alvo;
        if (alvo > atual && (alvo - atual) > PASSO_W)
            proximo = atual + PASSO_W;
        else if (atual > alvo && (atual - alvo) > PASSO_W)
            proximo = atual - PASSO_W;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alvo_codigo <= '0;
            atual       <= MIN_W;
            controle    <= 1'b0;
        end else begin
            if (carrega)
                alvo_codigo <= codigo;
            if (fim_periodo)
                atual <= proximo;
            controle <= habilita && (contador < atual);
        end
    end

endmodule

// File: rtl/controle_servo_multi.sv
// rtl/controle_servo_multi.sv - multi-channel servo PWM with shared period counter
module controle_servo_multi
    import controle_servo_multi_pkg::*;
#(
    parameter int N_CANAIS    = 2,
    parameter int POS_W       = 3,
    parameter int PERIODO     = PERIODO_PADRAO,
    parameter int LARGURA_MIN = LARGURA_MIN_PADRAO,
    parameter int LARGURA_MAX = LARGURA_MAX_PADRAO,
    parameter int PASSO       = PASSO_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      habilita,
    input  logic                      carrega,
    input  logic [N_CANAIS*POS_W-1:0] posicao,
    output logic [N_CANAIS-1:0]       controle,
    output logic                      pronto,
    output logic [N_CANAIS*POS_W-1:0] db_posicao,
    output logic                      db_reset
);

    localparam int CNT_W = largura_contador(PERIODO);
    localparam int DELTA = calc_delta(LARGURA_MIN, LARGURA_MAX, POS_W);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PERIODO - 1);

    logic [CNT_W-1:0]    contador;
    logic                fim_periodo;
    logic [N_CANAIS-1:0] pronto_canal;

    assign fim_periodo = habilita && (contador == ULTIMO);
    assign pronto      = &pronto_canal;
    assign db_reset    = reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            contador <= '0;
        else if (!habilita || contador == ULTIMO)
            contador <= '0;
        else
            contador <= contador + 1'b1;
    end

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        canal_servo #(
            .POS_W      (POS_W),
            .CNT_W      (CNT_W),
            .LARGURA_MIN(LARGURA_MIN),
            .DELTA      (DELTA),
            .PASSO      (PASSO)
        ) u_canal (
            .clock      (clock),
            .reset      (reset),
            .habilita   (habilita),
            .carrega    (carrega),
            .fim_periodo(fim_periodo),
            .codigo     (posicao[i*POS_W +: POS_W]),
            .contador   (contador),
            .controle   (controle[i]),
            .alvo_codigo(db_posicao[i*POS_W +: POS_W]),
            .pronto     (pronto_canal[i])
        );
    end

endmodule

// File: tb/tb_controle_servo_multi.sv
// tb/tb_controle_servo_multi.sv - scoreboard bench for controle_servo_multi
module tb_controle_servo_multi;

    localparam int N       = 2;
    localparam int PW      = 3;
    localparam int PERIODO = 100;
    localparam int LMIN    = 10;
    localparam int LMAX    = 80;
    localparam int PASSO   = 20;
    localparam int DELTA   = (LMAX - LMIN) / ((1 << PW) - 1);

    logic            clock = 1'b0;
    logic            reset;
    logic            habilita;
    logic            carrega;
    logic [N*PW-1:0] posicao;
    logic [N-1:0]    controle;
    logic            pronto;
    logic [N*PW-1:0] db_posicao;
    logic            db_reset;

    controle_servo_multi #(
        .N_CANAIS(N), .POS_W(PW), .PERIODO(PERIODO),
        .LARGURA_MIN(LMIN), .LARGURA_MAX(LMAX), .PASSO(PASSO)
    ) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .carrega(carrega),
        .posicao(posicao), .controle(controle), .pronto(pronto),
        .db_posicao(db_posicao), .db_reset(db_reset)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]    ctl;
        logic            pr;
        logic [N*PW-1:0] dbp;
    } esperado_t;

    esperado_t fila[$];
    int m_cnt;
    int m_alvo[N];
    int m_atual[N];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nome, input int atual, input int req);
        n_cmp++;
        if (atual != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nome, $time, atual, req);
        end
    endtask

    // Reference model: per-period bookkeeping in plain integers.
    always @(posedge clock) begin
        esperado_t e;
        bit todos;
        if (!reset) begin
            m_cnt = 0;
            for (int i = 0; i < N; i++) begin
                m_alvo[i]  = 0;
                m_atual[i] = LMIN;
            end
            e.ctl = '0;
        end else begin
            for (int i = 0; i < N; i++)
                e.ctl[i] = habilita && (m_cnt < m_atual[i]);
            if (habilita) begin
                if (m_cnt == PERIODO - 1) begin
                    for (int i = 0; i < N; i++) begin
                        int tgt, d;
                        tgt = LMIN + m_alvo[i] * DELTA;
                        d   = tgt - m_atual[i];
                        if (d > PASSO)       m_atual[i] += PASSO;
                        else if (d < -PASSO) m_atual[i] -= PASSO;
                        else                 m_atual[i] = tgt;
                    end
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_cnt = 0;
            end
            if (carrega)
                for (int i = 0; i < N; i++)
                    m_alvo[i] = int'(posicao[i*PW +: PW]);
        end
        todos = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m_atual[i] != LMIN + m_alvo[i] * DELTA) todos = 1'b0;
            e.dbp[i*PW +: PW] = PW'(m_alvo[i]);
        end
        e.pr = todos;
        fila.push_back(e);
    end

    always @(negedge clock) begin
        if (fila.size() > 0) begin
            esperado_t e;
            e = fila.pop_front();
            chk("controle", int'(controle), int'(e.ctl));
            chk("pronto", int'(pronto), int'(e.pr));
            chk("db_posicao", int'(db_posicao), int'(e.dbp));
            chk("db_reset", int'(db_reset), int'(reset));
        end
    end

    task automatic ciclo(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic pulso_carrega(input int c0, input int c1);
        posicao = {PW'(c1), PW'(c0)};
        carrega = 1'b1;
        ciclo();
        carrega = 1'b0;
    endtask

    task automatic pulso_reset();
        reset = 1'b0;
        fila.delete();
        #1;
        chk("reset_imediato_controle", int'(controle), 0);
        chk("reset_imediato_pronto", int'(pronto), 1);
        chk("reset_imediato_db_posicao", int'(db_posicao), 0);
        ciclo(2);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; habilita = 1'b0; carrega = 1'b0; posicao = '0;
        ciclo(3);
        reset = 1'b1;
        habilita = 1'b1;
        ciclo(2 * PERIODO);
        pulso_carrega(7, 0);
        ciclo(2 * PERIODO);
        pulso_carrega(2, 0);
        ciclo(3 * PERIODO);
        begin
            int k;
            k = 0;
            while (m_cnt != PERIODO - 1 && k < 2 * PERIODO) begin
                ciclo();
                k++;
            end
            chk("busca_fim_periodo", m_cnt, PERIODO - 1);
        end
        pulso_carrega(2, 1);
        ciclo(3 * PERIODO);
        pulso_carrega(7, 5);
        ciclo(PERIODO + 40);
        habilita = 1'b0;
        ciclo(30);
        habilita = 1'b1;
        ciclo(PERIODO + 60);
        pulso_reset();
        ciclo(2 * PERIODO);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                posicao = N*PW'($urandom);
                carrega = 1'b1;
            end else begin
                carrega = 1'b0;
            end
            if ($urandom_range(0, 299) == 0) habilita = ~habilita;
            if ($urandom_range(0, 999) == 0) begin
                carrega = 1'b0;
                pulso_reset();
            end
            ciclo();
        end
        carrega = 1'b0;
        ciclo(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
